// File: rtl/alu_operand_seq.sv
// Operand-capture stage for the 4-bit switch ALU: button synchronizer, debouncer,
// press detector and A/B/func capture FSM. Optional macro: DEBOUNCE_EN.
module alu_operand_seq #(
    parameter int DEB_CYCLES = 16,
    parameter int W          = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn,
    input  logic [15:0]    sw,
    input  logic [W+3:0]   res_in,
    output logic [W-1:0]   a,
    output logic [W-1:0]   b,
    output logic [2:0]     func,
    output logic           op_valid,
    output logic [W+3:0]   res_q,
    output logic [1:0]     state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        GOT_B = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync_b_q;
    logic           stable_q, stable_d;
    logic           stable_dly_q;
    logic           press_q;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     func_q, func_d;
    logic           op_valid_q, op_valid_d;
    logic [W+3:0]   res_lat_q;

    logic unused_sw;
    assign unused_sw = ^{sw[15:11], sw[7:W]};

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_b_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            stable_d = sync_b_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_deb_cycles = DEB_CYCLES;

    always_comb begin
        stable_d = sync_b_q;
    end
`endif

    // Two-flop synchronizer, debounced level, and rising-edge press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync_b_q     <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync_b_q     <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press_q) begin
            case (state_q)
                IDLE:    state_d = GOT_A;
                GOT_A:   state_d = GOT_B;
                GOT_B:   state_d = HOLD;
                HOLD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        func_d     = func_q;
        op_valid_d = 1'b0;
        if (press_q) begin
            case (state_q)
                IDLE:  a_d = sw[W-1:0];
                GOT_A: b_d = sw[W-1:0];
                GOT_B: begin
                    func_d     = sw[10:8];
                    op_valid_d = 1'b1;
                end
                HOLD: begin
                    a_d    = '0;
                    b_d    = '0;
                    func_d = '0;
                end
                default: ;
            endcase
        end
    end

    // res_in is sampled one edge after a/b/func settle, so the ALU has a full cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            func_q     <= '0;
            op_valid_q <= 1'b0;
            res_lat_q  <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            func_q     <= func_d;
            op_valid_q <= op_valid_d;
            if (op_valid_q) begin
                res_lat_q <= res_in;
            end
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign func     = func_q;
    assign op_valid = op_valid_q;
    assign res_q    = res_lat_q;
    assign state_o  = state_q;

endmodule
